hatch_arb: RTL and testbench

HATCH_ARB -- requirements
Module: hatch_arb

---
 rtl/hatch_pkg.sv | 20 ++
 rtl/hatch_arb_if.sv | 50 +++++
 rtl/hatch_burst_cnt.sv | 32 +++
 rtl/hatch_arb.sv | 122 ++++++++++++
 tb/tb_hatch_arb.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hatch_pkg                                                       |
// | Brief    : Shared FSM state encoding and default sizes for hatch_arb.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package hatch_pkg;

   localparam int c_dw    = 48;
   localparam int c_depth = 192;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_FLUSH = 2'd3
   } hatch_state_t;

endpackage
`default_nettype wire

// File: rtl/hatch_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hatch_arb_if                                                    |
// | Brief    : CPU fetch, loader and memory-port signals of hatch_arb.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface hatch_arb_if
   import hatch_pkg::*;
#(
   parameter int DW = c_dw,
   parameter int AW = 8
) ();

   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_gnt;
   logic          fetch_valid;
   logic [DW-1:0] fetch_data;
   logic          fetch_fault;
   logic          fetch_stall;
   logic          fetch_restart;

   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_lock;
   logic          ld_gnt;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, ld_lock, mem_rdata,
      output fetch_gnt, fetch_valid, fetch_data, fetch_fault, fetch_stall,
             fetch_restart, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
   );

   // CPU / loader / memory side
   modport master (
      output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, ld_lock, mem_rdata,
      input  fetch_gnt, fetch_valid, fetch_data, fetch_fault, fetch_stall,
             fetch_restart, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/hatch_burst_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hatch_burst_cnt                                                 |
// | Brief    : Saturating count of consecutive loader grants.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hatch_burst_cnt #(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic sat
);

   localparam int c_cw = $clog2(MAX_BURST + 1);

   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (inc && !sat) begin
         r_cnt <= r_cnt + c_cw'(1);
      end
   end

   assign sat = (r_cnt == c_cw'(MAX_BURST));

endmodule
`default_nettype wire

// File: rtl/hatch_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hatch_arb                                                       |
// | Brief    : Instruction-memory arbiter between CPU fetch and a loader.      |
// |            Define HATCH_ARB_FAIR_EN to bound loader bursts over fetches.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hatch_arb
   import hatch_pkg::*;
#(
   parameter int DEPTH        = c_depth,
   parameter int DW           = c_dw,
   parameter int AW           = 8,
   parameter int MAX_LD_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   hatch_arb_if.slave bus
);

   hatch_state_t r_state;
   hatch_state_t w_state_nxt;

   logic        r_fetch_valid;
   logic        r_fetch_fault;
   logic        r_rd_pending;
   logic        w_fetch_gnt;
   logic        w_ld_gnt;
   logic        w_burst_sat;
   logic        w_fetch_oob;
   logic        w_ld_oob;
   logic [31:0] w_fetch_idx;
   logic        w_unused;

   assign w_fetch_idx = {1'b0, bus.fetch_addr[31:1]};
   assign w_fetch_oob = (w_fetch_idx >= 32'(DEPTH));
   assign w_ld_oob    = (32'(bus.ld_addr) >= 32'(DEPTH));
   assign w_unused    = bus.fetch_addr[0];

`ifdef HATCH_ARB_FAIR_EN
   logic w_burst_clr;

   // Only RUN is fair; a locked loader owns the memory outright.
   assign w_burst_clr = w_fetch_gnt || !bus.fetch_req || (r_state != ST_RUN);

   hatch_burst_cnt #(
      .MAX_BURST (MAX_LD_BURST)
   ) u_burst_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_burst_clr),
      .inc (w_ld_gnt),
      .sat (w_burst_sat)
   );
`else
   localparam int c_unused_burst = MAX_LD_BURST;
   assign w_burst_sat = 1'b0;
`endif

   always_comb begin
      w_fetch_gnt = 1'b0;
      w_ld_gnt    = 1'b0;
      w_state_nxt = r_state;
      if (!rst) begin
         case (r_state)
            ST_RUN: begin
               if (bus.ld_req && !(w_burst_sat && bus.fetch_req)) begin
                  w_ld_gnt = 1'b1;
               end else if (bus.fetch_req) begin
                  w_fetch_gnt = 1'b1;
               end
               if (bus.ld_lock) begin
                  w_state_nxt = w_fetch_gnt ? ST_DRAIN : ST_LOAD;
               end
            end
            ST_DRAIN: begin
               w_ld_gnt    = bus.ld_req;
               w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               w_ld_gnt = bus.ld_req;
               if (!bus.ld_lock) begin
                  w_state_nxt = ST_FLUSH;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_fetch_valid <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_rd_pending  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_fetch_valid <= w_fetch_gnt;
         r_fetch_fault <= w_fetch_gnt && w_fetch_oob;
         r_rd_pending  <= w_fetch_gnt && !w_fetch_oob;
      end
   end

   // Out-of-range requests are still granted but never touch the memory.
   assign bus.fetch_gnt     = w_fetch_gnt;
   assign bus.ld_gnt        = w_ld_gnt;
   assign bus.mem_en        = (w_fetch_gnt && !w_fetch_oob) || (w_ld_gnt && !w_ld_oob);
   assign bus.mem_we        = w_ld_gnt && !w_ld_oob;
   assign bus.mem_addr      = w_ld_gnt    ? bus.ld_addr :
                              w_fetch_gnt ? w_fetch_idx[AW-1:0] : '0;
   assign bus.mem_wdata     = w_ld_gnt ? bus.ld_data : '0;
   assign bus.fetch_stall   = !rst && (r_state != ST_RUN);
   assign bus.fetch_restart = !rst && (r_state == ST_FLUSH);
   assign bus.fetch_valid   = !rst && r_fetch_valid;
   assign bus.fetch_fault   = !rst && r_fetch_fault;
   assign bus.fetch_data    = (!rst && r_rd_pending) ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_hatch_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hatch_arb                                                    |
// | Brief    : Directed bench for hatch_arb with a fetch-response scoreboard.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hatch_arb;

   typedef struct {
      int          cyc;
      bit          fault;
      logic [47:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   logic [47:0] mem [0:255];

   hatch_arb_if #(.DW(48), .AW(8)) bus ();

   hatch_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port memory, one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string nm, input logic [3:0] exp);
      chk(nm, 64'({bus.fetch_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we}), 64'(exp));
   endtask

   task automatic chk_sr(input string nm, input logic stall, input logic restart);
      chk(nm, 64'({bus.fetch_stall, bus.fetch_restart}), 64'({stall, restart}));
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_ctrl"}, 64'({bus.fetch_gnt, bus.fetch_valid, bus.fetch_fault, bus.fetch_stall,
                               bus.fetch_restart, bus.ld_gnt, bus.mem_en, bus.mem_we}), 64'(0));
      chk({nm, "_bus"}, 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
      chk({nm, "_data"}, 64'(bus.fetch_data), 64'(0));
   endtask

   task automatic push(input bit fault, input logic [47:0] data);
      exp_t e;
      e.cyc   = cyc + 1;
      e.fault = fault;
      e.data  = data;
      sbq.push_back(e);
   endtask

   task automatic fetch_cycle(input logic [31:0] addr, input bit en, input logic [47:0] data,
                              input bit fault);
      logic [7:0] idx;
      idx = addr[8:1];
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
      @(negedge clk);
      chk_gnt("fetch_gnt", {1'b1, 1'b0, en, 1'b0});
      if (en) chk("fetch_mem_addr", 64'(bus.mem_addr), 64'(idx));
      push(fault, data);
      tick();
   endtask

   task automatic ld_cycle(input logic [7:0] addr, input logic [47:0] data, input bit en);
      bus.ld_req  = 1'b1;
      bus.ld_addr = addr;
      bus.ld_data = data;
      @(negedge clk);
      chk_gnt("ld_gnt", {1'b0, 1'b1, en, en});
      if (en) chk("ld_mem_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'({addr, data}));
      tick();
   endtask

   task automatic clear_inputs();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.ld_req     = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_data    = '0;
      bus.ld_lock    = 1'b0;
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (bus.fetch_valid) begin
         if (sbq.size() == 0) begin
            chk("rsp_unexpected", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            chk("rsp_fault", 64'(bus.fetch_fault), 64'(e.fault));
            chk("rsp_data", 64'(bus.fetch_data), 64'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_f;
      for (int i = 0; i < 256; i++) mem[i] = 48'hC0DE_0000_0000 | 48'(i);
      bus.mem_rdata = '0;

      // Reset with requests active
      rst            = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      bus.ld_req     = 1'b1;
      bus.ld_addr    = 8'd5;
      bus.ld_data    = 48'h1;
      bus.ld_lock    = 1'b0;
      tick();
      @(negedge clk);
      chk_idle("reset");
      tick();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk_idle("post_reset");
      tick();

      // Fetches: back-to-back, out of range, last valid index
      fetch_cycle(32'h10,  1'b1, 48'hC0DE_0000_0008, 1'b0);
      fetch_cycle(32'h20,  1'b1, 48'hC0DE_0000_0010, 1'b0);
      fetch_cycle(32'h180, 1'b0, 48'h0, 1'b1);
      fetch_cycle(32'h17E, 1'b1, 48'hC0DE_0000_00BF, 1'b0);
      clear_inputs();
      tick();

      // Loader writes, in range and out of range, then read back
      ld_cycle(8'd20,  48'hABCD_1234_5678, 1'b1);
      ld_cycle(8'd200, 48'h0000_0000_0001, 1'b0);
      clear_inputs();
      fetch_cycle(32'h28, 1'b1, 48'hABCD_1234_5678, 1'b0);
      clear_inputs();
      tick();

      // Contention for 10 cycles
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h40;
      bus.ld_req     = 1'b1;
      bus.ld_addr    = 8'd40;
      bus.ld_data    = 48'h5A5A;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
`ifdef HATCH_ARB_FAIR_EN
         exp_f = ((i % 5) == 4);
`else
         exp_f = 1'b0;
`endif
         chk("arb_pattern", 64'({bus.fetch_gnt, bus.ld_gnt}), 64'({exp_f, !exp_f}));
         if (exp_f) push(1'b0, 48'hC0DE_0000_0020);
         tick();
      end
      clear_inputs();
      tick();

      // Lock raised with a fetch grant: DRAIN, LOAD, FLUSH, RUN
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      bus.ld_lock    = 1'b1;
      @(negedge clk);
      chk_gnt("lock_fetch_gnt", 4'b1010);
      chk_sr("lock_run_sr", 1'b0, 1'b0);
      push(1'b0, 48'hC0DE_0000_0008);
      tick();
      @(negedge clk);
      chk_gnt("drain_gnt", 4'b0000);
      chk_sr("drain_sr", 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.ld_req  = 1'b1;
         bus.ld_addr = 8'(50 + i);
         bus.ld_data = 48'h7_7000 + 48'(i);
         @(negedge clk);
         chk_gnt("load_gnt", 4'b0111);
         chk_sr("load_sr", 1'b1, 1'b0);
         chk("load_addr", 64'(bus.mem_addr), 64'(50 + i));
         tick();
      end
      bus.ld_req  = 1'b0;
      bus.ld_lock = 1'b0;
      @(negedge clk);
      chk_sr("unlock_sr", 1'b1, 1'b0);
      tick();
      @(negedge clk);
      chk_sr("flush_sr", 1'b1, 1'b1);
      chk_gnt("flush_gnt", 4'b0000);
      tick();
      bus.fetch_addr = 32'h68;
      @(negedge clk);
      chk_sr("rerun_sr", 1'b0, 1'b0);
      chk_gnt("rerun_gnt", 4'b1010);
      push(1'b0, 48'h0000_0007_7002);
      tick();
      clear_inputs();
      tick();

      // Lock dropped while draining still visits LOAD then FLUSH
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      bus.ld_lock    = 1'b1;
      @(negedge clk);
      chk_gnt("drop_fetch_gnt", 4'b1010);
      push(1'b0, 48'hC0DE_0000_0008);
      tick();
      bus.ld_lock = 1'b0;
      @(negedge clk);
      chk_sr("drop_drain_sr", 1'b1, 1'b0);
      tick();
      @(negedge clk);
      chk_sr("drop_load_sr", 1'b1, 1'b0);
      chk_gnt("drop_load_gnt", 4'b0000);
      tick();
      @(negedge clk);
      chk_sr("drop_flush_sr", 1'b1, 1'b1);
      tick();
      @(negedge clk);
      chk_sr("drop_run_sr", 1'b0, 1'b0);
      chk_gnt("drop_run_gnt", 4'b1010);
      push(1'b0, 48'hC0DE_0000_0008);
      tick();
      clear_inputs();
      tick();

      // Reset with a read in flight discards it
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      @(negedge clk);
      chk_gnt("flight_gnt", 4'b1010);
      tick();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      chk("flight_rst_valid", 64'(bus.fetch_valid), 64'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk_idle("flight_after");
      tick();

      // Reset during LOAD with a write pending
      bus.ld_lock = 1'b1;
      @(negedge clk);
      tick();
      bus.ld_req    = 1'b1;
      bus.ld_addr   = 8'd60;
      bus.ld_data   = 48'hDEAD;
      bus.fetch_req = 1'b1;
      @(negedge clk);
      chk_gnt("rload_gnt", 4'b0111);
      chk_sr("rload_sr", 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk_idle("rload_rst_a");
      tick();
      @(negedge clk);
      chk_idle("rload_rst_b");
      tick();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk_idle("rload_after");
      tick();

      repeat (2) tick();
      chk("sb_leftover", 64'(sbq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
